// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: character-stream front end for an HD44780-style LCD in 8-bit,
// write-only mode. After reset it runs the init sequence (0x38, 0x0C, 0x06,
// 0x01 plus CLR_SLOTS idle slots). It then accepts one character at a time and
// turns it into bus slots while tracking the cursor position.
//
// Optional feature: define LCD_SCROLL_EN to scroll on row overflow. Scrolling
// keeps a shadow copy of the screen and rewrites the whole display from it.
// Without the macro a row overflow clears the display instead, and no shadow
// buffer is built.
//
// Ports
//   i_clk          system clock (sole clock)
//   i_rst_n        asynchronous active-low reset
//   i_char_valid   character offered (held by the sender until accepted)
//   i_char_data    ASCII or control code (0x0D newline, 0x08 backspace, 0x0C clear)
//   o_char_ready   character accepted on a cycle with i_char_valid & o_char_ready
//   o_lcd_data     LCD data bus
//   o_lcd_rs       0 = command, 1 = data
//   o_lcd_rw       always 0
//   o_lcd_en       enable strobe: high DIV cycles, then low DIV cycles per slot
module lcd_char_ctrl #(
    parameter int DIV       = 250000,
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int CLR_SLOTS = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_char_valid,
    input  logic [7:0] i_char_data,
    output logic       o_char_ready,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en
);
    localparam int DW = $clog2(2 * DIV);
    localparam int WW = (CLR_SLOTS > 1) ? $clog2(CLR_SLOTS) : 1;

    typedef enum logic [3:0] {
        S_INIT_FUNC, S_INIT_DISP, S_INIT_MODE, S_CLEAR, S_CLR_WAIT, S_IDLE,
        S_SET_ADDR, S_WRITE, S_SCROLL, S_REF_ADDR, S_REF_DATA
    } state_t;

`ifdef LCD_SCROLL_EN
    localparam state_t OVF_STATE = S_SCROLL;
`else
    localparam state_t OVF_STATE = S_CLEAR;
`endif

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_div;
    logic [WW-1:0]   r_wait;
    logic [1:0]      r_row;
    logic [5:0]      r_col;
    logic [7:0]      r_char;
    logic            r_adv;       // 1: advance cursor after the write (printable)
    logic            r_ready, r_en, r_rs;
    logic [7:0]      r_data;
    logic            w_bus, w_slot, w_slot_end, w_accept, w_printable;
    logic            w_col_last, w_row_last, w_rs;
    logic [7:0]      w_data;

    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'(COLS);
            default: row_base = 8'(64 + COLS);
        endcase
    endfunction

`ifdef LCD_SCROLL_EN
    localparam int AW = $clog2(ROWS * COLS);
    logic [7:0]    r_shadow [ROWS*COLS];
    logic [1:0]    r_ref_row;
    logic [5:0]    r_ref_col;
    logic [AW-1:0] w_wr_idx, w_ref_idx;
    logic          w_ref_col_last;

    assign w_wr_idx       = AW'(int'(r_row) * COLS + int'(r_col));
    assign w_ref_idx      = AW'(int'(r_ref_row) * COLS + int'(r_ref_col));
    assign w_ref_col_last = (r_ref_col == 6'(COLS - 1));
`endif

    assign w_bus       = r_state inside {S_INIT_FUNC, S_INIT_DISP, S_INIT_MODE, S_CLEAR,
                                         S_SET_ADDR, S_WRITE, S_REF_ADDR, S_REF_DATA};
    assign w_slot      = w_bus || (r_state == S_CLR_WAIT);
    assign w_slot_end  = w_slot && (r_div == DW'(2 * DIV - 1));
    assign w_accept    = r_ready && i_char_valid;   // r_ready is only set in IDLE
    assign w_printable = (i_char_data >= 8'h20) && (i_char_data <= 8'h7E);
    assign w_col_last  = (r_col == 6'(COLS - 1));
    assign w_row_last  = (r_row == 2'(ROWS - 1));

    assign o_char_ready = r_ready;
    assign o_lcd_data   = r_data;
    assign o_lcd_rs     = r_rs;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_en     = r_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_INIT_FUNC;
        else          r_state <= w_state_nxt;
    end

    // NOTE: every signal assigned in this block gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_data      = 8'h00;
        w_rs        = 1'b0;
        case (r_state)
            S_INIT_FUNC: begin w_data = 8'h38; if (w_slot_end) w_state_nxt = S_INIT_DISP; end
            S_INIT_DISP: begin w_data = 8'h0C; if (w_slot_end) w_state_nxt = S_INIT_MODE; end
            S_INIT_MODE: begin w_data = 8'h06; if (w_slot_end) w_state_nxt = S_CLEAR; end
            S_CLEAR: begin
                w_data = 8'h01;
                if (w_slot_end) w_state_nxt = (CLR_SLOTS == 0) ? S_IDLE : S_CLR_WAIT;
            end
            S_CLR_WAIT:
                if (w_slot_end && r_wait == WW'(CLR_SLOTS - 1)) w_state_nxt = S_IDLE;
            S_IDLE:
                if (w_accept) begin
                    if (w_printable) w_state_nxt = S_SET_ADDR;
                    else begin
                        case (i_char_data)
                            8'h0D:   if (w_row_last) w_state_nxt = OVF_STATE;
                            8'h08:   if (r_row != '0 || r_col != '0) w_state_nxt = S_SET_ADDR;
                            8'h0C:   w_state_nxt = S_CLEAR;
                            default: ;  // unsupported code: dropped
                        endcase
                    end
                end
            S_SET_ADDR: begin
                w_data = 8'h80 | (row_base(r_row) + {2'b00, r_col});
                if (w_slot_end) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_data = r_char;
                w_rs   = 1'b1;
                if (w_slot_end)
                    w_state_nxt = (r_adv && w_col_last && w_row_last) ? OVF_STATE : S_IDLE;
            end
`ifdef LCD_SCROLL_EN
            S_SCROLL: w_state_nxt = S_REF_ADDR;
            S_REF_ADDR: begin
                w_data = 8'h80 | row_base(r_ref_row);
                if (w_slot_end) w_state_nxt = S_REF_DATA;
            end
            S_REF_DATA: begin
                w_data = r_shadow[w_ref_idx];
                w_rs   = 1'b1;
                if (w_slot_end && w_ref_col_last)
                    w_state_nxt = (r_ref_row == 2'(ROWS - 1)) ? S_IDLE : S_REF_ADDR;
            end
`endif
            default: ;
        endcase
    end

    // Bus outputs are registered and follow the state slot by one cycle, so the
    // data, RS and the EN rising edge all change together at bus-slot start.
    // On an overflow wrap the cursor stays on the last row at col 0: that is the
    // scroll end position, and the clear state zeroes it otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div   <= '0;
            r_wait  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_char  <= 8'h20;
            r_adv   <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples pre-edge values of the others.
            r_ready <= (r_state == S_IDLE) && !w_accept;
            r_en    <= w_bus && (r_div < DW'(DIV));
            if (w_bus && r_div == '0) begin
                r_data <= w_data;
                r_rs   <= w_rs;
            end
            if (w_slot_end)  r_div <= '0;
            else if (w_slot) r_div <= r_div + 1'b1;
            if (r_state != S_CLR_WAIT) r_wait <= '0;
            else if (w_slot_end)       r_wait <= r_wait + 1'b1;

            if (w_accept) begin
                if (w_printable) begin
                    r_char <= i_char_data;
                    r_adv  <= 1'b1;
                end else begin
                    case (i_char_data)
                        8'h0D: begin
                            r_col <= '0;
                            if (!w_row_last) r_row <= r_row + 1'b1;
                        end
                        8'h08: begin
                            r_char <= 8'h20;
                            r_adv  <= 1'b0;
                            if (r_col != '0) r_col <= r_col - 1'b1;
                            else if (r_row != '0) begin
                                r_row <= r_row - 1'b1;
                                r_col <= 6'(COLS - 1);
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (r_state == S_WRITE && w_slot_end && r_adv) begin
                if (!w_col_last) r_col <= r_col + 1'b1;
                else begin
                    r_col <= '0;
                    if (!w_row_last) r_row <= r_row + 1'b1;
                end
            end
            if (r_state == S_CLEAR) begin
                r_row <= '0;
                r_col <= '0;
            end
        end
    end

`ifdef LCD_SCROLL_EN
    // NOTE: the shadow buffer is reset explicitly because the display is
    // rebuilt from it; an unreset copy would paint garbage on the first scroll.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ROWS * COLS; i++) r_shadow[i] <= 8'h20;
        end else if (r_state == S_CLEAR) begin
            for (int i = 0; i < ROWS * COLS; i++) r_shadow[i] <= 8'h20;
        end else if (r_state == S_SCROLL) begin
            // Shift everything up one row; the last row becomes blank.
            for (int i = 0; i < ROWS * COLS; i++)
                r_shadow[i] <= (i < (ROWS - 1) * COLS) ? r_shadow[(i + COLS) % (ROWS * COLS)]
                                                       : 8'h20;
        end else if (r_state == S_WRITE && w_slot_end) begin
            r_shadow[w_wr_idx] <= r_char;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ref_row <= '0;
            r_ref_col <= '0;
        end else if (r_state == S_SCROLL) begin
            r_ref_row <= '0;
            r_ref_col <= '0;
        end else if (r_state == S_REF_DATA && w_slot_end) begin
            if (w_ref_col_last) begin
                r_ref_col <= '0;
                r_ref_row <= r_ref_row + 1'b1;
            end else begin
                r_ref_col <= r_ref_col + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Testbench for lcd_char_ctrl (DIV=2, COLS=16, ROWS=2, CLR_SLOTS=2).
// A bus monitor records every completed EN pulse as {rs,data}. A cursor and
// screen model built from the display rules predicts the writes each character
// should cause.
`timescale 1ns/1ps
module tb_lcd_char_ctrl;
    localparam int DIV = 2, COLS = 16, ROWS = 2, CLR_SLOTS = 2;
    localparam int LIMIT = 4000;

    logic       clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
    logic [7:0] cdata = 8'h00;
    logic       ready, rs, rw, en;
    logic [7:0] data;

    always #5 clk = ~clk;

    lcd_char_ctrl #(.DIV(DIV), .COLS(COLS), .ROWS(ROWS), .CLR_SLOTS(CLR_SLOTS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_char_valid(valid), .i_char_data(cdata),
        .o_char_ready(ready), .o_lcd_data(data), .o_lcd_rs(rs), .o_lcd_rw(rw), .o_lcd_en(en)
    );

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    logic [8:0] bus_q[$];
    int         lo_q[$];
    logic       prev_en = 1'b0, seen = 1'b0;
    int         hi_cnt = 0, lo_cnt = 0;
    logic [8:0] rise_val = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0; seen = 1'b0; hi_cnt = 0; lo_cnt = 0;
        end else begin
            if (en && !prev_en) begin
                if (seen) begin
                    lo_q.push_back(lo_cnt);
                    check("en_low_min", lo_cnt >= DIV, 1);
                end
                seen = 1'b1; hi_cnt = 1; rise_val = {rs, data};
            end else if (en) begin
                hi_cnt++;
            end else if (prev_en) begin
                check("en_high_len", hi_cnt, DIV);
                check("bus_stable", {rs, data}, rise_val);
                check("lcd_rw", rw, 0);
                bus_q.push_back({rs, data});
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
            prev_en = en;
        end
    end

    function automatic logic [8:0] bus_at(input int i);
        if (i >= 0 && i < bus_q.size()) return bus_q[i];
        return 9'h1FF;
    endfunction

    function automatic int lo_at(input int i);
        if (i >= 0 && i < lo_q.size()) return lo_q[i];
        return -1;
    endfunction

    // ---------------- reference model ----------------
    int         m_row = 0, m_col = 0;
    logic [7:0] m_shadow [ROWS][COLS];
    logic [8:0] exp_q[$];

    function automatic logic [7:0] base(input int r);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'h40;
        if (r == 2) return 8'(COLS);
        return 8'(64 + COLS);
    endfunction

    task automatic m_blank();
        m_row = 0; m_col = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_shadow[r][c] = 8'h20;
    endtask

    task automatic m_clear();
        exp_q.push_back({1'b0, 8'h01});
        m_blank();
    endtask

    task automatic m_put(input int r, input int c, input logic [7:0] ch);
        exp_q.push_back({1'b0, 8'h80 | (base(r) + 8'(c))});
        exp_q.push_back({1'b1, ch});
        m_shadow[r][c] = ch;
    endtask

    task automatic m_overflow();
`ifdef LCD_SCROLL_EN
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) m_shadow[r][c] = m_shadow[r+1][c];
        for (int c = 0; c < COLS; c++) m_shadow[ROWS-1][c] = 8'h20;
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back({1'b0, 8'h80 | base(r)});
            for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, m_shadow[r][c]});
        end
        m_row = ROWS - 1; m_col = 0;
`else
        m_clear();
`endif
    endtask

    task automatic model(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            m_put(m_row, m_col, ch);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0; m_row++;
                if (m_row == ROWS) m_overflow();
            end
        end else if (ch == 8'h0D) begin
            m_col = 0; m_row++;
            if (m_row == ROWS) m_overflow();
        end else if (ch == 8'h08) begin
            if (m_col > 0) begin
                m_col--; m_put(m_row, m_col, 8'h20);
            end else if (m_row > 0) begin
                m_row--; m_col = COLS - 1; m_put(m_row, m_col, 8'h20);
            end
        end else if (ch == 8'h0C) begin
            m_clear();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] ch);
        int n = 0;
        @(negedge clk);
        valid = 1'b1; cdata = ch;
        while (!ready && n < LIMIT) begin @(negedge clk); n++; end
        check("accept_timeout", n < LIMIT, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        check("ready_drop", ready, 0);
        model(ch);
    endtask

    task automatic drain();
        int n = 0;
        while (!ready && n < LIMIT) begin @(negedge clk); n++; end
        check("drain_timeout", n < LIMIT, 1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, bus_q.size(), exp_q.size());
        while (bus_q.size() > 0 && exp_q.size() > 0) check(tag, bus_q.pop_front(), exp_q.pop_front());
        bus_q.delete(); exp_q.delete();
    endtask

    task automatic release_and_init(input string tag);
        int cyc = 0;
        bus_q.delete(); lo_q.delete(); exp_q.delete();
        m_blank();
        @(negedge clk); rst_n = 1'b1;
        while (!ready && cyc < LIMIT) begin @(negedge clk); cyc++; end
        check({tag, "_ready_timeout"}, cyc < LIMIT, 1);
        check({tag, "_ready_early"}, cyc >= (4 + CLR_SLOTS) * 2 * DIV, 1);
        check({tag, "_ready_late"}, cyc <= (4 + CLR_SLOTS) * 2 * DIV + 2, 1);
        check({tag, "_writes"}, bus_q.size(), 4);
        check({tag, "_w0"}, bus_at(0), 9'h038);
        check({tag, "_w1"}, bus_at(1), 9'h00C);
        check({tag, "_w2"}, bus_at(2), 9'h006);
        check({tag, "_w3"}, bus_at(3), 9'h001);
        for (int i = 0; i < 3; i++) check({tag, "_low_len"}, lo_at(i), DIV);
        bus_q.delete(); lo_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch;
        int         sel, n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_en", en, 0);
        check("rst_data", data, 8'h00);
        check("rst_rs", rs, 0);
        check("rst_rw", rw, 0);
        check("rst_ready", ready, 0);

        release_and_init("init");

        // Single characters at the home position.
        send(8'h41); drain();
        check("A_addr", bus_at(0), 9'h080);
        check("A_data", bus_at(1), 9'h141);
        compare("char_A");
        send(8'h42); drain();
        check("B_addr", bus_at(0), 9'h081);
        check("B_data", bus_at(1), 9'h142);
        compare("char_B");

        // Fill row 0, then the 17th char must go to row 1.
        for (int i = 0; i < 14; i++) send(8'($urandom_range(32, 126)));
        drain(); compare("row0_fill");
        send(8'h58); drain();
        check("wrap_addr", bus_at(0), 9'h0C0);
        check("wrap_data", bus_at(1), 9'h158);
        compare("wrap");

        // Unsupported codes: no bus activity and no cursor movement.
        send(8'h01); send(8'h7F); send(8'h0A); send(8'h9B); drain();
        compare("dropped");
        send(8'h5A); drain();
        check("after_drop_addr", bus_at(0), 9'h0C1);
        compare("after_drop");

        // Clear, newline and backspace.
        send(8'h0C); drain();
        check("clear_cmd", bus_at(0), 9'h001);
        compare("clear");
        for (int i = 0; i < 5; i++) send(8'h48 + 8'(i));
        drain(); compare("five");
        send(8'h0D); drain(); compare("newline");
        send(8'h51); drain();
        check("nl_addr", bus_at(0), 9'h0C0);
        check("nl_data", bus_at(1), 9'h151);
        compare("after_newline");
        send(8'h08); drain(); compare("bs_col1");
        send(8'h08); drain();
        check("bs_row_addr", bus_at(0), 9'h08F);
        check("bs_row_data", bus_at(1), 9'h120);
        compare("bs_row");
        send(8'h0C); send(8'h08); drain(); compare("bs_home");

        // Fill the screen and overflow.
        for (int i = 0; i < 32; i++) send(8'($urandom_range(32, 126)));
        drain();
`ifdef LCD_SCROLL_EN
        check("ovf_last", bus_at(bus_q.size() - 1), 9'h120);
`else
        check("ovf_last", bus_at(bus_q.size() - 1), 9'h001);
`endif
        compare("fill32");
        send(8'h4B); drain();
`ifdef LCD_SCROLL_EN
        check("c33_addr", bus_at(0), 9'h0C0);
`else
        check("c33_addr", bus_at(0), 9'h080);
`endif
        check("c33_data", bus_at(1), 9'h14B);
        compare("char33");

        // Newline on the last row overflows too.
        send(8'h0C); send(8'h41); send(8'h0D); send(8'h42); send(8'h0D); drain();
        compare("nl_overflow");

        // Random burst; characters are held while the block is busy.
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 19);
            if (sel < 14)       ch = 8'($urandom_range(32, 126));
            else if (sel < 16)  ch = 8'h0D;
            else if (sel == 16) ch = 8'h08;
            else if (sel == 17) ch = 8'h0C;
            else                ch = 8'($urandom_range(128, 255));
            send(ch);
        end
        drain(); compare("random_burst");

        // Reset in the middle of a data write with EN high.
        send(8'h4D);
        n = 0;
        @(negedge clk);
        while (!(en && rs) && n < LIMIT) begin @(negedge clk); n++; end
        check("write_slot_timeout", n < LIMIT, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en", en, 0);
        check("midrst_data", data, 8'h00);
        check("midrst_ready", ready, 0);
        repeat (2) @(negedge clk);
        release_and_init("reinit");
        send(8'h52); drain();
        check("post_rst_addr", bus_at(0), 9'h080);
        check("post_rst_data", bus_at(1), 9'h152);
        compare("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_char_ctrl.md
LCD_CHAR_CTRL -- requirements
Module: lcd_char_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 250000, meaning clock cycles per LCD_EN half-period (one bus slot = 2*DIV cycles), legal range ≥2.
REQ-002 SHALL have parameter COLS, default 16, meaning characters per row, legal range 8..40.
REQ-003 SHALL have parameter ROWS, default 2, meaning display rows, legal range 1..4.
REQ-004 SHALL have parameter CLR_SLOTS, default 2, meaning extra idle slots after each clear command.
REQ-005 SHALL have ports: clock  in  1  system clock (sole clock); reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: char_valid  in  1  character offered; char_data  in  8  ASCII code or control code; char_ready  out  1  block accepts a character this cycle.
REQ-007 SHALL have ports: LCD_DATA  out  8  HD44780 bus; LCD_RS  out  1  0=command, 1=data; LCD_RW  out  1  constant 0 (write only); LCD_EN  out  1  enable strobe.

Function
REQ-008 SHALL run one bus slot per state: LCD_DATA/LCD_RS driven at slot start, LCD_EN high for first DIV cycles and low for last DIV cycles, data stable across the falling edge.
REQ-009 SHALL execute the init sequence after reset: INIT_FUNC 0x38, INIT_DISP 0x0C, INIT_MODE 0x06, INIT_CLR 0x01 followed by CLR_SLOTS idle slots (LCD_EN held 0), then IDLE.
REQ-010 SHALL assert char_ready only in IDLE with no slot in progress; a character is accepted on the cycle where char_valid and char_ready are both 1; char_ready drops the following cycle.
REQ-011 SHALL, for a printable code (0x20..0x7E), issue SET_ADDR (0x80 | rowbase[row] + col) then WRITE (RS=1, code), then advance col; return to IDLE.
REQ-012 SHALL use rowbase = {0x00, 0x40, COLS, 0x40+COLS} for rows 0..3.
REQ-013 SHALL treat 0x0D as newline: col=0, row=row+1, with no bus write unless a row overflow occurs (REQ-016).
REQ-014 SHALL treat 0x08 as backspace: at col>0, col=col-1 and write 0x20 at the new position; at col=0, row>0, move to row-1, col COLS-1 and write 0x20; at (0,0), no bus activity.
REQ-015 SHALL treat 0x0C as clear: issue 0x01 plus CLR_SLOTS wait slots, set row=col=0, and fill the shadow buffer with 0x20; any other code SHALL be dropped, with no bus activity or cursor change.
REQ-016 SHALL, when col reaches COLS, wrap to col 0 of the next row; when the row exceeds ROWS-1, take the overflow action of REQ-022 or REQ-023.
REQ-017 SHALL maintain a ROWS*COLS shadow buffer, updated on every data write, backspace and clear.
REQ-018 SHALL hold a character offered while char_ready=0 (sender's obligation); a held request SHALL NOT be lost or duplicated.

Reset
REQ-019 SHALL, on reset low, asynchronously force: LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, char_ready=0, row=col=0, divider=0, state=INIT_FUNC.
REQ-020 SHALL, on reset asserted mid-slot, truncate the slot immediately, with no EN glitch beyond the forced 0, and restart the full init sequence after release.
REQ-021 SHALL reset the shadow buffer to all 0x20.

Configuration
REQ-022 SHALL, with macro LCD_SCROLL_EN defined, on row overflow: copy shadow rows 1..ROWS-1 up one row, blank the last row, then rewrite the whole display through REFRESH_ADDR/REFRESH_DATA slots (one SET_ADDR per row, COLS data writes per row), and end at row ROWS-1, col 0; char_ready stays 0 throughout.
REQ-023 SHALL, without LCD_SCROLL_EN, on row overflow: perform a clear (REQ-015) and continue at (0,0); the shadow buffer may be omitted.

Verification
REQ-024 SHALL cover: DIV=2, reset release -> bus sequence 0x38, 0x0C, 0x06, 0x01 with RS=0, each EN high 2 cycles / low 2 cycles, char_ready first high after the 4+CLR_SLOTS slots.
REQ-025 SHALL cover: "A" (0x41) at (0,0) -> 0x80 with RS=0, then 0x41 with RS=1; "B" -> 0x81, 0x42.
REQ-026 SHALL cover: 16 chars then "X", COLS=16 -> 17th write preceded by address 0xC0.
REQ-027 SHALL cover: 0x0D at (0,5), then "Q" -> 0xC0, 0x51; 0x08 at (1,0) -> 0x8F, 0x20.
REQ-028 SHALL cover: with LCD_SCROLL_EN, 33 chars on a 16x2 display -> refresh writes row 0 = old row 1 and row 1 = spaces, then the 33rd char at 0xC0; without the macro -> 0x01 then the char at 0x80.
REQ-029 SHALL cover: reset pulsed during a WRITE slot with EN high -> EN=0 the same cycle and init restarts with 0x38.
